karatsuba_seq_ctrl: RTL

//  Sequential one-level Karatsuba multiplier: state register, operand/partial-product registers, combine stage.

---
 rtl/karatsuba_pkg.sv | 29 ++
 rtl/karatsuba_next_state.sv | 26 ++
 rtl/karatsuba_seq_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential one-level Karatsuba multiplier:
// state encoding and the width helpers derived from the operand width.
package karatsuba_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S0 = 3'b000,  // IDLE
        S1 = 3'b001,  // SUM
        S2 = 3'b010,  // Z0
        S3 = 3'b011,  // Z2
        S4 = 3'b100,  // Z1
        S5 = 3'b101   // COMBINE
    } state_e;

    function automatic int half_w(input int n);
        return n / 2;
    endfunction

    // Half sums keep their carry, so they are one bit wider than a half operand.
    function automatic int sum_w(input int n);
        return (n / 2) + 1;
    endfunction

    function automatic int prod_w(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/karatsuba_next_state.sv
// Combinational next-state decoder for the Karatsuba sequencer.
// ack_i must already be qualified with an outstanding request.
module karatsuba_next_state
    import karatsuba_pkg::*;
(
    input  state_e state_i,
    input  logic   start_i,
    input  logic   ack_i,
    output state_e state_o
);

    // Advance through the three sub-products; unused encodings fall back to idle.
    always_comb begin
        state_o = S0;
        case (state_i)
            S0:      state_o = start_i ? S1 : S0;
            S1:      state_o = S2;
            S2:      state_o = ack_i ? S3 : S2;
            S3:      state_o = ack_i ? S4 : S3;
            S4:      state_o = ack_i ? S5 : S4;
            S5:      state_o = S0;
            default: state_o = S0;
        endcase
    end

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential one-level Karatsuba multiplier: owns the state register, the
// operand and partial-product registers, and the final combine stage.
module karatsuba_seq_ctrl
    import karatsuba_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic [WIDTH-1:0]            x_i,
    input  logic [WIDTH-1:0]            y_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [2*WIDTH-1:0]          p_o,
    output logic                        mul_req_o,
    output logic [sum_w(WIDTH)-1:0]     mul_a_o,
    output logic [sum_w(WIDTH)-1:0]     mul_b_o,
    input  logic                        mul_ack_i,
    input  logic [prod_w(WIDTH)-1:0]    mul_p_i
);

    localparam int N  = WIDTH;
    localparam int H  = half_w(WIDTH);
    localparam int SW = sum_w(WIDTH);
    localparam int PW = prod_w(WIDTH);
    localparam int RW = 2 * WIDTH;

    state_e          state_q;
    state_e          state_d;
    logic            busy_q;
    logic            done_q;
    logic [RW-1:0]   p_q;
    logic            mul_req_q;
    logic [SW-1:0]   mul_a_q;
    logic [SW-1:0]   mul_b_q;
    logic [N-1:0]    xr_q;
    logic [N-1:0]    yr_q;
    logic [SW-1:0]   sx_q;
    logic [SW-1:0]   sy_q;
    logic [PW-1:0]   z0_q;
    logic [PW-1:0]   z2_q;
    logic [PW-1:0]   zm_q;

    logic            ack_s;
    logic [SW-1:0]   sx_s;
    logic [SW-1:0]   sy_s;
    logic [PW-1:0]   z1_s;
    logic [RW-1:0]   p_s;

    // An acknowledge only counts while a request is actually outstanding.
    assign ack_s = mul_ack_i & mul_req_q;

    assign sx_s = SW'(xr_q[H-1:0]) + SW'(xr_q[N-1:H]);
    assign sy_s = SW'(yr_q[H-1:0]) + SW'(yr_q[N-1:H]);
    assign z1_s = zm_q - z0_q - z2_q;
    assign p_s  = (RW'(z2_q) << N) + (RW'(z1_s) << H) + RW'(z0_q);

    karatsuba_next_state u_next_state (
        .state_i (state_q),
        .start_i (start_i),
        .ack_i   (ack_s),
        .state_o (state_d)
    );

    // Sequencer state, handshake outputs and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= S0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            p_q       <= '0;
            mul_req_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            xr_q      <= '0;
            yr_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            z0_q      <= '0;
            z2_q      <= '0;
            zm_q      <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S0);
            case (state_q)
                S0: begin
                    if (start_i) begin
                        xr_q   <= x_i;
                        yr_q   <= y_i;
                        done_q <= 1'b0;
                    end
                end
                S1: begin
                    sx_q      <= sx_s;
                    sy_q      <= sy_s;
                    mul_req_q <= 1'b1;
                    mul_a_q   <= SW'(xr_q[H-1:0]);
                    mul_b_q   <= SW'(yr_q[H-1:0]);
                end
                S2: begin
                    if (ack_s) begin
                        z0_q      <= mul_p_i;
                        mul_req_q <= 1'b0;
                        mul_a_q   <= SW'(xr_q[N-1:H]);
                        mul_b_q   <= SW'(yr_q[N-1:H]);
                    end
                end
                // Operands change only during the single request-low cycle.
                S3: begin
                    if (ack_s) begin
                        z2_q      <= mul_p_i;
                        mul_req_q <= 1'b0;
                        mul_a_q   <= sx_q;
                        mul_b_q   <= sy_q;
                    end else begin
                        mul_req_q <= 1'b1;
                    end
                end
                S4: begin
                    if (ack_s) begin
                        zm_q      <= mul_p_i;
                        mul_req_q <= 1'b0;
                    end else begin
                        mul_req_q <= 1'b1;
                    end
                end
                S5: begin
                    p_q    <= p_s;
                    done_q <= 1'b1;
                end
                default: begin
                    done_q    <= 1'b0;
                    mul_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign p_o       = p_q;
    assign mul_req_o = mul_req_q;
    assign mul_a_o   = mul_a_q;
    assign mul_b_o   = mul_b_q;

endmodule
